// File: rtl/sdram_tester.sv
// SDRAM wrapper exerciser: single store/load, pattern fill and pattern verify with timeout.
// Define SDRAM_TESTER_LFSR_EN to replace the incrementing pattern by a Galois LFSR.
module sdram_tester #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 26,
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [1:0]        i_mode,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [LEN_W-1:0]  i_len,
   input  logic [DATA_W-1:0] i_data,
   input  logic [DATA_W-1:0] i_seed,
   output logic              o_sdram_write,
   output logic              o_sdram_read,
   output logic [ADDR_W-1:0] o_sdram_addr,
   output logic [DATA_W-1:0] o_sdram_data,
   input  logic [DATA_W-1:0] i_sdram_data,
   input  logic              i_sdram_valid,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_busy,
   output logic              o_done,
   output logic [15:0]       o_err_cnt,
   output logic              o_timeout,
   output logic [1:0]        o_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int TO_W = $clog2(TIMEOUT + 1);

`ifdef SDRAM_TESTER_LFSR_EN
   localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(16'hB400);

   function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] p);
      return (p >> 1) ^ (p[0] ? LFSR_TAPS : '0);
   endfunction

   // An all-zero state would lock the LFSR, so seed 0 is promoted to 1.
   function automatic logic [DATA_W-1:0] pat_seed(input logic [DATA_W-1:0] s);
      return (s == '0) ? DATA_W'(1) : s;
   endfunction
`else
   function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] p);
      return p + 1'b1;
   endfunction

   function automatic logic [DATA_W-1:0] pat_seed(input logic [DATA_W-1:0] s);
      return s;
   endfunction
`endif

   state_t            state_q, state_d;
   logic              pmode_q, pmode_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [15:0]       err_q, err_d;
   logic              timeout_q, timeout_d;

   // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         pmode_q   <= 1'b0;
         addr_q    <= '0;
         pat_q     <= '0;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         to_q      <= '0;
         rdata_q   <= '0;
         err_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pmode_q   <= pmode_d;
         addr_q    <= addr_d;
         pat_q     <= pat_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         to_q      <= to_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         timeout_q <= timeout_d;
      end
   end

   // NOTE: every _d gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d   = state_q;
      pmode_d   = pmode_q;
      addr_d    = addr_q;
      pat_d     = pat_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      to_d      = to_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      timeout_d = timeout_q;

      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               pmode_d   = i_mode[1];
               addr_d    = i_base_addr;
               pat_d     = i_mode[1] ? pat_seed(i_seed) : i_data;
               cnt_d     = i_mode[1] ? i_len : LEN_W'(1);
               to_d      = '0;
               err_d     = '0;
               timeout_d = 1'b0;
               if (i_mode[1] && (i_len == '0)) begin
                  req_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  req_d   = 1'b1;
                  state_d = i_mode[0] ? READ : WRITE;
               end
            end
         end

         WRITE, READ: begin
            if (req_q) begin
               if (i_sdram_valid) begin
                  // Dropping the request after each ack yields the mandatory idle cycle.
                  req_d = 1'b0;
                  to_d  = '0;
                  if (state_q == READ) begin
                     rdata_d = i_sdram_data;
                     if (pmode_q && (i_sdram_data != pat_q) && (err_q != 16'hFFFF))
                        err_d = err_q + 16'd1;
                  end
                  if (cnt_q == LEN_W'(1)) begin
                     state_d = DONE;
                  end else begin
                     cnt_d  = cnt_q - 1'b1;
                     addr_d = addr_q + 1'b1;
                     if (pmode_q)
                        pat_d = pat_next(pat_q);
                  end
               end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                  req_d     = 1'b0;
                  timeout_d = 1'b1;
                  state_d   = DONE;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end else begin
               req_d = 1'b1;
            end
         end

         DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   assign o_sdram_write = (state_q == WRITE) && req_q;
   assign o_sdram_read  = (state_q == READ) && req_q;
   assign o_sdram_addr  = addr_q;
   assign o_sdram_data  = pat_q;
   assign o_rdata       = rdata_q;
   assign o_busy        = (state_q == WRITE) || (state_q == READ);
   assign o_done        = (state_q == DONE);
   assign o_err_cnt     = err_q;
   assign o_timeout     = timeout_q;
   assign o_state       = state_q;

endmodule
